spdif_tx: RTL and testbench

SPDIF_TX -- requirements
Module: spdif_tx

---
 rtl/spdif_pkg.sv | 65 ++++++
 rtl/spdif_tick_gen.sv | 47 ++++
 rtl/spdif_tx.sv | 160 ++++++++++++++++
 tb/tb_spdif_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// ----------------------------------------------------------------------------
// spdif_pkg
// Shared constants and types for the S/PDIF transmitter:
//   - subframe geometry (cells, slots, audio width)
//   - B/M/W preamble cell patterns (for a preceding line level of 0)
//   - fixed slot indices for V, U, C and P
//   - frame length and the 192-bit channel-status constant
//   - sample payload struct and the tick-divider width helper
// ----------------------------------------------------------------------------
package spdif_pkg;

  // Payload and counter widths
  localparam int unsigned AUDIO_W   = 24;
  localparam int unsigned CELL_W    = 7;    // 2 subframes x 32 slots x 2 halves
  localparam int unsigned SLOT_W    = 5;
  localparam int unsigned FRAME_W   = 8;
  localparam int unsigned FRAME_LEN = 192;

  // Preamble cell patterns, first cell in the MSB, for a preceding level of 0
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  // Slot map inside one subframe
  localparam logic [SLOT_W-1:0] SLOT_AUDIO0 = 5'd4;
  localparam logic [SLOT_W-1:0] SLOT_V      = 5'd28;
  localparam logic [SLOT_W-1:0] SLOT_U      = 5'd29;
  localparam logic [SLOT_W-1:0] SLOT_C      = 5'd30;
  localparam logic [SLOT_W-1:0] SLOT_P      = 5'd31;

  // Channel status: only copy-permitted (bit 2) and 48 kHz (bit 25) are set
  localparam logic [FRAME_LEN-1:0] CHAN_STATUS =
    (FRAME_LEN'(1) << 2) | (FRAME_LEN'(1) << 25);

  typedef enum logic [1:0] {
    PRE_SEL_B = 2'd0,
    PRE_SEL_M = 2'd1,
    PRE_SEL_W = 2'd2
  } pre_sel_e;

  // Sample pair held for one full frame
  typedef struct packed {
    logic               v;
    logic [AUDIO_W-1:0] left;
    logic [AUDIO_W-1:0] right;
  } sample_t;

  // Accumulator width for the fractional tick divider
  function automatic int unsigned acc_width(input int unsigned step);
    return $clog2(step) + 1;
  endfunction

  // Cell pattern for a preamble type
  function automatic logic [7:0] preamble_bits(input pre_sel_e sel);
    logic [7:0] bits;
    bits = PRE_W;
    case (sel)
      PRE_SEL_B: bits = PRE_B;
      PRE_SEL_M: bits = PRE_M;
      default:   bits = PRE_W;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/spdif_tick_gen.sv
// ----------------------------------------------------------------------------
// spdif_tick_gen
// Fractional clock divider producing one pulse per half-bit cell.
// Average clocks per cell = ACC_STEP / 2^ACC_FRAC.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   tick - registered one-clock pulse per cell
// ----------------------------------------------------------------------------
module spdif_tick_gen
  import spdif_pkg::*;
#(
  parameter int unsigned ACC_STEP = 132,
  parameter int unsigned ACC_FRAC = 5
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned ACC_W = acc_width(ACC_STEP);
  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(1 << ACC_FRAC);
  localparam logic [ACC_W-1:0] ACC_DEN = ACC_W'(ACC_STEP);

  logic [ACC_W-1:0] r_acc;
  logic             r_tick;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;

  // Increment never exceeds the step, so the sum stays below 2*ACC_STEP
  assign w_sum  = r_acc + ACC_INC;
  assign w_wrap = (w_sum >= ACC_DEN);

  // Accumulator and registered tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_wrap ? (w_sum - ACC_DEN) : w_sum;
      r_tick <= w_wrap;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/spdif_tx.sv
// ----------------------------------------------------------------------------
// spdif_tx
// S/PDIF biphase-mark transmitter for 24-bit stereo samples.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   audio_l    - left sample, latched in the ack cycle
//   audio_r    - right sample, latched in the ack cycle
//   valid      - sample pair present, latched in the ack cycle
//   ack        - one-clock pulse when the pair is consumed (start of frame)
//   spdif      - registered biphase-mark line
//   spdif_tick - one-clock pulse per half-bit cell
// ----------------------------------------------------------------------------
module spdif_tx
  import spdif_pkg::*;
#(
  parameter int unsigned ACC_STEP = 132,
  parameter int unsigned ACC_FRAC = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AUDIO_W-1:0] audio_l,
  input  logic [AUDIO_W-1:0] audio_r,
  input  logic               valid,
  output logic               ack,
  output logic               spdif,
  output logic               spdif_tick
);

  localparam logic [CELL_W-1:0]  CELL_LAST  = CELL_W'(127);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_LEN - 1);

  logic               w_tick;
  logic [CELL_W-1:0]  r_cell;
  logic [FRAME_W-1:0] r_frame;
  sample_t            r_smp;
  logic               r_spdif;
  logic               r_pol;

  logic               w_sub;
  logic [SLOT_W-1:0]  w_slot;
  logic               w_half;
  logic               w_is_pre;
  logic               w_sf_start;
  logic               w_frame_start;
  logic [AUDIO_W-1:0] w_audio;
  logic [SLOT_W-1:0]  w_aidx;
  logic [AUDIO_W-1:0] w_audio_sh;
  logic               w_c;
  logic               w_par;
  logic               w_bit;
  pre_sel_e           w_pre_sel;
  logic [7:0]         w_pre_bits;
  logic               w_pol;
  logic               w_line;
  sample_t            w_smp_next;

  // Cell-rate strobe
  spdif_tick_gen #(
    .ACC_STEP (ACC_STEP),
    .ACC_FRAC (ACC_FRAC)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Cell counter decode: [6] subframe, [5:1] slot, [0] half-cell
  assign w_sub         = r_cell[6];
  assign w_slot        = r_cell[5:1];
  assign w_half        = r_cell[0];
  assign w_is_pre      = (r_cell[5:3] == 3'd0);
  assign w_sf_start    = (r_cell[5:0] == 6'd0);
  assign w_frame_start = (r_cell == '0);

  // Subframe payload bits
  assign w_audio    = w_sub ? r_smp.right : r_smp.left;
  assign w_aidx     = w_slot - SLOT_AUDIO0;
  assign w_audio_sh = w_audio >> w_aidx;
  assign w_c        = CHAN_STATUS[r_frame];
  assign w_par      = ^{w_audio, r_smp.v, 1'b0, w_c};

  // Bit carried by the current slot
  always_comb begin
    w_bit = 1'b0;
    case (w_slot)
      SLOT_V:  w_bit = r_smp.v;
      SLOT_U:  w_bit = 1'b0;
      SLOT_C:  w_bit = w_c;
      SLOT_P:  w_bit = w_par;
      default: w_bit = w_is_pre ? 1'b0 : w_audio_sh[0];
    endcase
  end

  // Preamble type: W on right, B on left of frame 0, M otherwise
  always_comb begin
    w_pre_sel = PRE_SEL_W;
    if (!w_sub) begin
      w_pre_sel = (r_frame == '0) ? PRE_SEL_B : PRE_SEL_M;
    end
  end

  assign w_pre_bits = preamble_bits(w_pre_sel);

  // Preamble polarity is the line level just before the subframe's first cell
  assign w_pol = w_sf_start ? r_spdif : r_pol;

  // Next line level for the cell starting on this tick
  always_comb begin
    w_line = r_spdif;
    if (w_is_pre) begin
      w_line = w_pre_bits[~r_cell[2:0]] ^ w_pol;
    end else if (!w_half) begin
      w_line = ~r_spdif;
    end else begin
      w_line = r_spdif ^ w_bit;
    end
  end

  // A missing sample pair is sent as silence flagged invalid
  always_comb begin
    w_smp_next.v     = 1'b1;
    w_smp_next.left  = '0;
    w_smp_next.right = '0;
    if (valid) begin
      w_smp_next.v     = 1'b0;
      w_smp_next.left  = audio_l;
      w_smp_next.right = audio_r;
    end
  end

  // Counters, sample latch and line register advance only on ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cell  <= '0;
      r_frame <= '0;
      r_smp   <= '0;
      r_spdif <= 1'b0;
      r_pol   <= 1'b0;
    end else if (w_tick) begin
      r_spdif <= w_line;
      r_cell  <= r_cell + CELL_W'(1);
      if (w_sf_start) begin
        r_pol <= r_spdif;
      end
      if (w_frame_start) begin
        r_smp <= w_smp_next;
      end
      if (r_cell == CELL_LAST) begin
        r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + FRAME_W'(1);
      end
    end
  end

  // ack is a decode of registered state so it lands in the tick cycle itself
  assign ack        = w_tick & w_frame_start;
  assign spdif      = r_spdif;
  assign spdif_tick = w_tick;

endmodule

// File: tb/tb_spdif_tx.sv
module tb_spdif_tx;

  logic        clk = 1'b0;
  logic        rst_d, rst_f;
  logic [23:0] audio_l, audio_r;
  logic        valid;
  logic        ack_d, spdif_d, tick_d;
  logic        ack_f, spdif_f, tick_f;

  always #5 clk = ~clk;

  // Default-rate instance
  spdif_tx u_dut (
    .clk        (clk),
    .rst        (rst_d),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .valid      (valid),
    .ack        (ack_d),
    .spdif      (spdif_d),
    .spdif_tick (tick_d)
  );

  // One cell per clock, for long multi-frame runs
  spdif_tx #(.ACC_STEP(32), .ACC_FRAC(5)) u_fast (
    .clk        (clk),
    .rst        (rst_f),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .valid      (valid),
    .ack        (ack_f),
    .spdif      (spdif_f),
    .spdif_tick (tick_f)
  );

  int   checks = 0;
  int   errors = 0;
  logic sel = 1'b0;
  logic cap_en = 1'b0;
  bit   cells [0:32767];
  bit   ackm  [0:32767];
  int   ncell = 0;
  bit   pend = 1'b0;
  bit   pend_ack = 1'b0;
  logic m_spdif, m_tick, m_ack;

  assign m_spdif = sel ? spdif_f : spdif_d;
  assign m_tick  = sel ? tick_f  : tick_d;
  assign m_ack   = sel ? ack_f   : ack_d;

  // Record the line level of each cell (visible one clock after its tick)
  always @(negedge clk) begin
    if (!cap_en) begin
      ncell    = 0;
      pend     = 1'b0;
      pend_ack = 1'b0;
    end else begin
      if (pend && ncell < 32768) begin
        cells[ncell] = m_spdif;
        ackm[ncell]  = pend_ack;
        ncell++;
      end
      pend     = m_tick;
      pend_ack = m_ack;
    end
  end

  function automatic bit cell_at(input int i);
    return (i < 0) ? 1'b0 : cells[i];
  endfunction

  function automatic logic [7:0] pre_of(input int base);
    logic [7:0] p;
    bit pv;
    pv = cell_at(base - 1);
    for (int k = 0; k < 8; k++) p[7-k] = cells[base+k] ^ pv;
    return p;
  endfunction

  function automatic bit bit_of(input int base, input int slot);
    return cells[base+2*slot] ^ cells[base+2*slot+1];
  endfunction

  function automatic logic [23:0] audio_of(input int base);
    logic [23:0] a;
    for (int i = 0; i < 24; i++) a[i] = bit_of(base, 4 + i);
    return a;
  endfunction

  function automatic int bmc_err(input int base);
    int e;
    e = 0;
    for (int s = 4; s < 32; s++)
      if (cells[base+2*s] == cell_at(base + 2*s - 1)) e++;
    return e;
  endfunction

  function automatic bit par_ok(input int base);
    bit x;
    x = 1'b0;
    for (int s = 4; s < 31; s++) x ^= bit_of(base, s);
    return x == bit_of(base, 31);
  endfunction

  task automatic start_dut(input logic use_fast);
    cap_en = 1'b0;
    sel    = use_fast;
    rst_d  = 1'b0;
    rst_f  = 1'b0;
    repeat (3) @(negedge clk);
    cap_en = 1'b1;
    if (use_fast) rst_f = 1'b1;
    else          rst_d = 1'b1;
  endtask

  task automatic wait_cells(input int n, input int budget);
    int c;
    c = 0;
    while (ncell < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (ncell < n) begin
      errors++;
      $display("FAIL capture_timeout got %0d cells need %0d", ncell, n);
    end
  endtask

  task automatic wait_ack_d(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ack_d && c < budget);
    checks++;
    if (!ack_d) begin
      errors++;
      $display("FAIL ack_timeout no ack within %0d clocks", budget);
    end
  endtask

  task automatic test_reset;
    rst_d = 1'b0; rst_f = 1'b0;
    audio_l = '0; audio_r = '0; valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (spdif_d !== 1'b0) begin errors++; $display("FAIL reset_spdif got %b exp 0", spdif_d); end
    checks++; if (ack_d !== 1'b0)   begin errors++; $display("FAIL reset_ack got %b exp 0", ack_d); end
    checks++; if (tick_d !== 1'b0)  begin errors++; $display("FAIL reset_tick got %b exp 0", tick_d); end
    checks++; if (spdif_f !== 1'b0) begin errors++; $display("FAIL reset_spdif_fast got %b exp 0", spdif_f); end
  endtask

  task automatic test_tick_rate;
    int nt, first, last, bad_gap, nack, bad_ack;
    nt = 0; first = -1; last = 0; bad_gap = 0; nack = 0; bad_ack = 0;
    valid = 1'b1;
    start_dut(1'b0);
    for (int i = 1; i <= 1320; i++) begin
      @(negedge clk);
      if (ack_d === 1'b1) begin
        nack++;
        if (tick_d !== 1'b1 || (nt % 128) != 0) bad_ack++;
      end
      if (tick_d === 1'b1) begin
        if (first < 0) first = i;
        else if ((i - last) != 4 && (i - last) != 5) bad_gap++;
        last = i;
        nt++;
      end
    end
    checks++; if (first != 5)   begin errors++; $display("FAIL first_tick got clock %0d exp 5", first); end
    checks++; if (nt != 320)    begin errors++; $display("FAIL tick_count got %0d exp 320", nt); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL tick_gap got %0d bad gaps exp 0", bad_gap); end
    checks++; if (nack != 3)    begin errors++; $display("FAIL ack_count got %0d exp 3", nack); end
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL ack_spacing got %0d misplaced exp 0", bad_ack); end
  endtask

  task automatic test_data;
    audio_l = 24'h000400; audio_r = 24'h800000; valid = 1'b1;
    start_dut(1'b1);
    wait_cells(129, 2000);
    checks++; if (ackm[0] !== 1'b1)        begin errors++; $display("FAIL data_ack0 got %b exp 1", ackm[0]); end
    checks++; if (ackm[128] !== 1'b1)      begin errors++; $display("FAIL data_ack128 got %b exp 1", ackm[128]); end
    checks++; if (pre_of(0) !== 8'hE8)     begin errors++; $display("FAIL data_pre_l got %h exp e8", pre_of(0)); end
    checks++; if (pre_of(64) !== 8'hE4)    begin errors++; $display("FAIL data_pre_r got %h exp e4", pre_of(64)); end
    checks++; if (audio_of(0) !== 24'h000400)  begin errors++; $display("FAIL data_left got %h exp 000400", audio_of(0)); end
    checks++; if (audio_of(64) !== 24'h800000) begin errors++; $display("FAIL data_right got %h exp 800000", audio_of(64)); end
    checks++; if (bit_of(0, 28) !== 1'b0 || bit_of(64, 28) !== 1'b0)
      begin errors++; $display("FAIL data_v got %b%b exp 00", bit_of(0, 28), bit_of(64, 28)); end
    checks++; if (bit_of(0, 31) !== 1'b1 || bit_of(64, 31) !== 1'b1)
      begin errors++; $display("FAIL data_p got %b%b exp 11", bit_of(0, 31), bit_of(64, 31)); end
    checks++; if (bmc_err(0) + bmc_err(64) != 0)
      begin errors++; $display("FAIL data_bmc got %0d errors exp 0", bmc_err(0) + bmc_err(64)); end
    checks++; if (cells[63] !== 1'b0 || cells[127] !== 1'b0)
      begin errors++; $display("FAIL data_end_level got %b%b exp 00", cells[63], cells[127]); end
  endtask

  task automatic test_invalid;
    audio_l = 24'h123456; audio_r = 24'hABCDEF; valid = 1'b0;
    start_dut(1'b0);
    wait_ack_d(20);
    @(posedge clk); #1 valid = 1'b1;
    wait_ack_d(600);
    @(posedge clk); #1 audio_l = 24'hFFFFFF; audio_r = 24'h000000;
    wait_cells(257, 1400);
    checks++; if (audio_of(0) !== 24'h0 || audio_of(64) !== 24'h0)
      begin errors++; $display("FAIL inv_audio got %h %h exp 0 0", audio_of(0), audio_of(64)); end
    checks++; if (bit_of(0, 28) !== 1'b1 || bit_of(64, 28) !== 1'b1)
      begin errors++; $display("FAIL inv_v got %b%b exp 11", bit_of(0, 28), bit_of(64, 28)); end
    checks++; if (bit_of(0, 31) !== 1'b1 || bit_of(64, 31) !== 1'b1)
      begin errors++; $display("FAIL inv_p got %b%b exp 11", bit_of(0, 31), bit_of(64, 31)); end
    checks++; if (pre_of(128) !== 8'hE2) begin errors++; $display("FAIL next_pre got %h exp e2", pre_of(128)); end
    checks++; if (audio_of(128) !== 24'h123456) begin errors++; $display("FAIL next_left got %h exp 123456", audio_of(128)); end
    checks++; if (audio_of(192) !== 24'hABCDEF) begin errors++; $display("FAIL next_right got %h exp abcdef", audio_of(192)); end
    checks++; if (bit_of(128, 28) !== 1'b0 || bit_of(192, 28) !== 1'b0)
      begin errors++; $display("FAIL next_v got %b%b exp 00", bit_of(128, 28), bit_of(192, 28)); end
    checks++; if (!par_ok(128) || !par_ok(192) || !par_ok(0) || !par_ok(64))
      begin errors++; $display("FAIL inv_parity got odd parity exp even"); end
    checks++; if (bmc_err(0) + bmc_err(64) + bmc_err(128) + bmc_err(192) != 0)
      begin errors++; $display("FAIL inv_bmc got nonzero errors exp 0"); end
  endtask

  task automatic test_frames;
    int bad_pre, nb, bad_c, nc, bad_par, bmc, nack, bad_ackpos;
    bad_pre = 0; nb = 0; bad_c = 0; nc = 0; bad_par = 0; bmc = 0; nack = 0; bad_ackpos = 0;
    audio_l = 24'h000001; audio_r = 24'h000002; valid = 1'b1;
    start_dut(1'b1);
    wait_cells(193 * 128 + 1, 30000);
    for (int f = 0; f < 193; f++) begin
      int  lb, rb;
      bit  cexp;
      lb = f * 128;
      rb = lb + 64;
      cexp = (f == 2 || f == 25);
      if (pre_of(lb) !== (((f == 0) || (f == 192)) ? 8'hE8 : 8'hE2)) bad_pre++;
      if (pre_of(rb) !== 8'hE4) bad_pre++;
      if (pre_of(lb) === 8'hE8) nb++;
      if (bit_of(lb, 30) != cexp || bit_of(rb, 30) != cexp) bad_c++;
      if (bit_of(lb, 30)) nc++;
      if (!par_ok(lb) || !par_ok(rb)) bad_par++;
      bmc += bmc_err(lb) + bmc_err(rb);
      if (ackm[lb] !== 1'b1) bad_ackpos++;
    end
    for (int i = 0; i < 193 * 128; i++) if (ackm[i]) nack++;
    checks++; if (bad_pre != 0)    begin errors++; $display("FAIL frames_pre got %0d bad exp 0", bad_pre); end
    checks++; if (nb != 2)         begin errors++; $display("FAIL frames_b_count got %0d exp 2", nb); end
    checks++; if (bad_c != 0)      begin errors++; $display("FAIL frames_c got %0d bad exp 0", bad_c); end
    checks++; if (nc != 2)         begin errors++; $display("FAIL frames_c_count got %0d exp 2", nc); end
    checks++; if (bad_par != 0)    begin errors++; $display("FAIL frames_parity got %0d bad exp 0", bad_par); end
    checks++; if (bmc != 0)        begin errors++; $display("FAIL frames_bmc got %0d exp 0", bmc); end
    checks++; if (nack != 193)     begin errors++; $display("FAIL frames_ack_count got %0d exp 193", nack); end
    checks++; if (bad_ackpos != 0) begin errors++; $display("FAIL frames_ack_pos got %0d bad exp 0", bad_ackpos); end
  endtask

  task automatic test_reset_midframe;
    int c, bad;
    audio_l = 24'h00000F; audio_r = 24'h0; valid = 1'b1;
    start_dut(1'b0);
    repeat (700) @(negedge clk);
    c = 0;
    while (spdif_d !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    cap_en = 1'b0;
    rst_d  = 1'b0;
    #1;
    checks++; if (spdif_d !== 1'b0) begin errors++; $display("FAIL midrst_spdif_async got %b exp 0", spdif_d); end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (spdif_d !== 1'b0 || ack_d !== 1'b0 || tick_d !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_hold got %0d bad cycles exp 0", bad); end
    cap_en = 1'b1;
    rst_d  = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (tick_d !== 1'b1 && c < 20);
    checks++; if (c != 5) begin errors++; $display("FAIL midrst_first_tick got clock %0d exp 5", c); end
    wait_cells(64, 400);
    checks++; if (ackm[0] !== 1'b1)    begin errors++; $display("FAIL midrst_ack got %b exp 1", ackm[0]); end
    checks++; if (pre_of(0) !== 8'hE8) begin errors++; $display("FAIL midrst_pre got %h exp e8", pre_of(0)); end
    checks++; if (audio_of(0) !== 24'h00000F) begin errors++; $display("FAIL midrst_left got %h exp 00000f", audio_of(0)); end
  endtask

  initial begin
    test_reset;
    test_tick_rate;
    test_data;
    test_invalid;
    test_frames;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
